// File: rtl/ppu_vram_arb.sv
// Nametable banks + palette store; cfg port acks 3 cycles after req when uncontended, PPU reads return the next cycle.
// Backpressure: cfg loses bank conflicts to the PPU for at most STARVE_MAX WAIT cycles, then wins and the PPU read is dropped.
module ppu_vram_arb #(
  parameter int NT_BANKS   = 4,
  parameter int NT_AW      = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic        i_ppu_clk,
  input  logic        i_ppu_rstn,
  input  logic        i_cfg_req,
  input  logic        i_cfg_we,
  input  logic [13:0] i_cfg_addr,
  input  logic [7:0]  i_cfg_wdata,
  output logic        o_cfg_ack,
  output logic [7:0]  o_cfg_rdata,
  input  logic [2:0]  i_mirror_mode,
  input  logic        i_gray,
  input  logic        i_nt_req,
  input  logic [11:0] i_nt_addr,
  output logic        o_nt_valid,
  output logic [7:0]  o_nt_rdata,
  input  logic [4:0]  i_plt_addr,
  output logic [7:0]  o_plt_rdata
);

  localparam logic [1:0] BMASK = 2'(NT_BANKS - 1);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  function automatic logic [1:0] bank_sel(input logic [2:0] mode, input logic a11, input logic a10);
    logic [1:0] b;
    case (mode)
      3'd0:    b = {1'b0, a11};
      3'd1:    b = {1'b0, a10};
      3'd2:    b = 2'd0;
      3'd3:    b = 2'd1;
      3'd5:    b = {1'b0, a11 ^ a10};
      default: b = {a11, a10};
    endcase
    return b & BMASK;
  endfunction

  // Sprite-zero slots 0x10/14/18/1C share storage with the background slots.
  function automatic logic [4:0] pal_alias(input logic [4:0] idx);
    return (idx[4] && idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
  endfunction

  state_t          state, state_nxt;
  logic            issue, starve_inc;
  logic [13:0]     c_addr;
  logic            c_we;
  logic [7:0]      c_wdata;
  logic [1:0]      c_bank;
  logic [SW-1:0]   starve;
  logic [7:0]      rbuf;
  logic [7:0]      pal [32];
  logic [3:0][7:0] bank_q;
  logic [1:0]      ppu_bank, ppu_bank_q;

  logic c_unmapped, c_pal, c_nt, needs_nt, nt_issue, pal_wr, conflict;

  assign c_unmapped = ~c_addr[13];
  assign c_pal      = (c_addr[13:8] == 6'h3F);
  assign c_nt       = ~c_unmapped & ~c_pal;
  assign needs_nt   = c_nt | (c_pal & ~c_we);
  assign ppu_bank   = bank_sel(i_mirror_mode, i_nt_addr[11], i_nt_addr[10]);
  assign conflict   = needs_nt && i_nt_req && (ppu_bank == c_bank);
  assign nt_issue   = issue & needs_nt;
  assign pal_wr     = issue & c_pal & c_we;

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    starve_inc = 1'b0;
    case (state)
      S_IDLE: if (i_cfg_req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!conflict || starve == SW'(STARVE_MAX)) begin
          issue     = 1'b1;
          state_nxt = S_RESP;
        end else begin
          starve_inc = 1'b1;
        end
      end
      S_RESP: state_nxt = S_DONE;
      S_DONE: if (!i_cfg_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    if (b < NT_BANKS) begin : g_ram
      logic [7:0]       mem [2**NT_AW];
      logic             cfg_hit, en, we;
      logic [NT_AW-1:0] addr;
      assign cfg_hit = nt_issue && (c_bank == 2'(b));
      assign en      = cfg_hit || (i_nt_req && ppu_bank == 2'(b));
      assign we      = cfg_hit && c_we;
      assign addr    = cfg_hit ? c_addr[NT_AW-1:0] : i_nt_addr[NT_AW-1:0];
      always_ff @(posedge i_ppu_clk) begin
        if (we) mem[addr] <= c_wdata;
      end
      always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
        if (!i_ppu_rstn)    bank_q[b] <= 8'h00;
        else if (en && !we) bank_q[b] <= mem[addr];
      end
    end else begin : g_none
      assign bank_q[b] = 8'h00;
    end
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      o_nt_valid <= 1'b0;
      ppu_bank_q <= 2'd0;
    end else begin
      o_nt_valid <= i_nt_req && !(nt_issue && c_bank == ppu_bank);
      if (i_nt_req) ppu_bank_q <= ppu_bank;
    end
  end
  assign o_nt_rdata = bank_q[ppu_bank_q];

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      c_addr      <= 14'h0;
      c_we        <= 1'b0;
      c_wdata     <= 8'h00;
      c_bank      <= 2'd0;
      starve      <= '0;
      rbuf        <= 8'h00;
      o_cfg_ack   <= 1'b0;
      o_cfg_rdata <= 8'h00;
    end else begin
      o_cfg_ack <= 1'b0;
      if (state == S_IDLE && i_cfg_req) begin
        c_addr  <= i_cfg_addr;
        c_we    <= i_cfg_we;
        c_wdata <= i_cfg_wdata;
        c_bank  <= bank_sel(i_mirror_mode, i_cfg_addr[11], i_cfg_addr[10]);
      end
      if (issue)           starve <= '0;
      else if (starve_inc) starve <= starve + 1'b1;
      if (state == S_RESP) begin
        o_cfg_ack <= 1'b1;
        if (c_unmapped) begin
          o_cfg_rdata <= rbuf;
        end else if (c_we) begin
          o_cfg_rdata <= 8'h00;
        end else begin
          o_cfg_rdata <= c_pal ? pal[pal_alias(c_addr[4:0])] : rbuf;
          rbuf        <= bank_q[c_bank];
        end
      end
    end
  end

  // PPU read samples the pre-write value when cfg writes the same index this cycle.
  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      for (int i = 0; i < 32; i++) pal[i] <= 8'h00;
      o_plt_rdata <= 8'h00;
    end else begin
      if (pal_wr) pal[pal_alias(c_addr[4:0])] <= c_wdata;
      o_plt_rdata <= pal[(i_plt_addr[1:0] == 2'b00) ? 5'h00 : i_plt_addr] & (i_gray ? 8'h30 : 8'hFF);
    end
  end

endmodule
